fc_weight_buffer: RTL and testbench
===================================

FC_WEIGHT_BUFFER -- requirements
Module: fc_weight_buffer

Interface
REQ-001 Parameter DEPTH, default 96, words per bank (4 int8 weights per word).
REQ-002 Parameter LANES, default 12, words delivered to the MMU per sub-cycle (12 PEs × 4 taps).
REQ-003 Parameter DW, default 32, word width in bits.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-low; ports clk and rst_n.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 load_en  input  1  write load_data into the shadow bank this cycle.
REQ-008 load_k_word  input  7  shadow word index, legal range 0..DEPTH-1.
REQ-009 load_data  input  DW  weight word to write.
REQ-010 swap  input  1  single-cycle pulse that exchanges the shadow and active banks.
REQ-011 rd_en  input  1  MMU read strobe; the controller drives it with mmu_valid_in.
REQ-012 rd_sub_cycle  input  3  selects active words rd_sub_cycle*LANES .. +LANES-1.
REQ-013 rd_data  output  LANES*DW  registered lane words; lane i occupies bits [i*DW +: DW].
REQ-014 rd_valid  output  1  rd_data valid, one cycle after rd_en.
REQ-015 shadow_cnt  output  7  number of loads accepted into the shadow bank since the last swap.
REQ-016 active_words  output  7  word count latched into the active bank at the last swap.
REQ-017 err_oob  output  1  sticky flag for an out-of-range load index or read window.

Function
REQ-018 Storage: two banks of DEPTH×DW; bank_sel names the active bank, and the other bank is the shadow bank.
REQ-019 Load path: load_en=1 with load_k_word<DEPTH writes shadow[load_k_word] at the clock edge and increments shadow_cnt, saturating at DEPTH.
REQ-020 load_en=1 with load_k_word>=DEPTH performs no write, leaves shadow_cnt unchanged and sets err_oob.
REQ-021 Swap: on swap=1, bank_sel toggles, active_words is loaded with shadow_cnt, and shadow_cnt is cleared to 0.
REQ-022 Swap with a simultaneous load: the write lands in the pre-swap shadow bank and is counted, so active_words = shadow_cnt+1, saturated at DEPTH.
REQ-023 Read: with rd_en=1, at the next edge rd_data lane i takes active[rd_sub_cycle*LANES+i], and rd_valid=1.
REQ-024 Read latency is exactly 1 cycle, and back-to-back reads are supported every cycle.
REQ-025 Zero padding: any lane whose index is >= active_words outputs 0 (example: active_words=24 gives rd_sub_cycle 2..7 all zero).
REQ-026 A read window whose start index rd_sub_cycle*LANES is >= DEPTH returns all zeros and sets err_oob.
REQ-027 Read with a simultaneous swap: the read uses the pre-swap active bank and the pre-swap active_words.
REQ-028 With rd_en=0, rd_valid goes to 0 and rd_data holds its previous value.
REQ-029 A load to an index already written overwrites that word and still increments shadow_cnt; duplicate loads are not detected.
REQ-030 err_oob clears only on reset.

Reset
REQ-031 When rst_n=0 at an edge: bank_sel=0, shadow_cnt=0, active_words=0, rd_valid=0, rd_data=0, err_oob=0.
REQ-032 Bank memory contents are not reset; they read as zero through REQ-025 because active_words=0.
REQ-033 A reset in the middle of a load or read sequence aborts it; the first post-reset load starts a fresh count from 0.

Structure
REQ-034 The shared package fc_pkg holds DEPTH, LANES, DW, the N_ACC_L1=2 and N_ACC_L2=8 constants, and the word-index width.
REQ-035 One sub-module, fc_wbuf_bank, is a single-port-write / wide-read register bank; it is instantiated twice.
REQ-036 Bank selection, counters and the read mux live in the top level of this block.

Verification
REQ-037 Reset, then a read at sub_cycle 0: rd_valid=1 after 1 cycle and rd_data=0.
REQ-038 Load words 0..23 with data k+1 (k = word index), swap, read sub_cycles 0 and 1: lanes return 1..12 and 13..24; sub_cycle 2 returns all 0; active_words=24.
REQ-039 Load 96 words, swap, read sub_cycle 7: lanes return words 84..95; active_words=96; shadow_cnt=0.
REQ-040 Swap in the same cycle as a load to k_word 5 (the 10th load): the write goes to the old shadow and active_words=10; a following read returns the new data at word 5.
REQ-041 Swap in the same cycle as a read: the read returns the old active bank; the next read returns the new bank.
REQ-042 Load with k_word=100: no write, err_oob=1 and stays set; assert rst_n=0 mid-load: all outputs clear as in REQ-031.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared constants for the fully-connected layer datapath: buffer geometry,
// accumulator depths and the word-index width.
package fc_pkg;

  localparam int DEPTH    = 96;
  localparam int LANES    = 12;
  localparam int DW       = 32;
  localparam int N_ACC_L1 = 2;
  localparam int N_ACC_L2 = 8;
  localparam int KW       = 7;

endpackage

// File: rtl/fc_wbuf_bank.sv
// One weight bank: single write port, every word visible at once on a wide
// read bus. Contents are deliberately left unreset.
module fc_wbuf_bank
  import fc_pkg::*;
#(
  parameter int DEPTH = fc_pkg::DEPTH,
  parameter int DW    = fc_pkg::DW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [KW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata [DEPTH]
);

  logic [DW-1:0] mem_q [DEPTH];

  // Word write; the caller only asserts we for in-range addresses
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q;

endmodule

// File: rtl/fc_weight_buffer.sv
// Double-buffered FC weight store: loads fill the shadow bank while the MMU
// reads LANES-word windows from the active bank; swap exchanges them.
module fc_weight_buffer
  import fc_pkg::*;
#(
  parameter int DEPTH = fc_pkg::DEPTH,
  parameter int LANES = fc_pkg::LANES,
  parameter int DW    = fc_pkg::DW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_en,
  input  logic [KW-1:0]       load_k_word,
  input  logic [DW-1:0]       load_data,
  input  logic                swap,
  input  logic                rd_en,
  input  logic [2:0]          rd_sub_cycle,
  output logic [LANES*DW-1:0] rd_data,
  output logic                rd_valid,
  output logic [KW-1:0]       shadow_cnt,
  output logic [KW-1:0]       active_words,
  output logic                err_oob
);

  logic                bank_sel_q, bank_sel_d;
  logic [KW-1:0]       shadow_cnt_q, shadow_cnt_d;
  logic [KW-1:0]       active_words_q, active_words_d;
  logic                rd_valid_q, rd_valid_d;
  logic [LANES*DW-1:0] rd_data_q, rd_data_d;
  logic                err_oob_q, err_oob_d;

  logic                load_ok_s;
  logic [KW-1:0]       cnt_inc_s;
  logic [31:0]         start_s;
  logic [31:0]         idx_s;
  logic                win_oob_s;
  logic [LANES*DW-1:0] lanes_s;
  logic [DW-1:0]       rd_b0_s [DEPTH];
  logic [DW-1:0]       rd_b1_s [DEPTH];

  // Bank 0 is the shadow when bank_sel=1, bank 1 when bank_sel=0
  fc_wbuf_bank #(.DEPTH(DEPTH), .DW(DW)) u_bank0 (
    .clk   (clk),
    .we    (load_ok_s && bank_sel_q),
    .waddr (load_k_word),
    .wdata (load_data),
    .rdata (rd_b0_s)
  );

  fc_wbuf_bank #(.DEPTH(DEPTH), .DW(DW)) u_bank1 (
    .clk   (clk),
    .we    (load_ok_s && !bank_sel_q),
    .waddr (load_k_word),
    .wdata (load_data),
    .rdata (rd_b1_s)
  );

  // Load accounting, bank swap and sticky error
  always_comb begin
    load_ok_s      = load_en && (32'(load_k_word) < DEPTH);
    bank_sel_d     = bank_sel_q;
    active_words_d = active_words_q;
    if (load_ok_s && (32'(shadow_cnt_q) < DEPTH)) begin
      cnt_inc_s = shadow_cnt_q + 7'd1;
    end else begin
      cnt_inc_s = shadow_cnt_q;
    end
    // A load coinciding with swap is counted into the outgoing shadow
    if (swap) begin
      bank_sel_d     = ~bank_sel_q;
      active_words_d = cnt_inc_s;
      shadow_cnt_d   = 7'd0;
    end else begin
      shadow_cnt_d   = cnt_inc_s;
    end
    err_oob_d = err_oob_q
              | (load_en && !load_ok_s)
              | (rd_en && win_oob_s);
  end

  // Read window mux with zero padding beyond the loaded word count
  always_comb begin
    start_s   = 32'(rd_sub_cycle) * LANES;
    win_oob_s = (start_s >= DEPTH);
    idx_s     = 32'd0;
    lanes_s   = '0;
    for (int i = 0; i < LANES; i++) begin
      idx_s = start_s + 32'(i);
      if (!win_oob_s && (idx_s < 32'(active_words_q))) begin
        lanes_s[i*DW +: DW] = bank_sel_q ? rd_b1_s[idx_s[KW-1:0]]
                                         : rd_b0_s[idx_s[KW-1:0]];
      end else begin
        lanes_s[i*DW +: DW] = '0;
      end
    end
    if (rd_en) begin
      rd_data_d = lanes_s;
    end else begin
      rd_data_d = rd_data_q;
    end
    rd_valid_d = rd_en;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_sel_q     <= 1'b0;
      shadow_cnt_q   <= 7'd0;
      active_words_q <= 7'd0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
      err_oob_q      <= 1'b0;
    end else begin
      bank_sel_q     <= bank_sel_d;
      shadow_cnt_q   <= shadow_cnt_d;
      active_words_q <= active_words_d;
      rd_valid_q     <= rd_valid_d;
      rd_data_q      <= rd_data_d;
      err_oob_q      <= err_oob_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign shadow_cnt   = shadow_cnt_q;
  assign active_words = active_words_q;
  assign err_oob      = err_oob_q;

endmodule

// File: tb/tb_fc_weight_buffer.sv
// Directed bench for fc_weight_buffer: load/swap/read scenarios with
// hand-computed lane values.
module tb_fc_weight_buffer;

  localparam int DEPTH = 96;
  localparam int LANES = 12;
  localparam int DW    = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                load_en;
  logic [6:0]          load_k_word;
  logic [DW-1:0]       load_data;
  logic                swap;
  logic                rd_en;
  logic [2:0]          rd_sub_cycle;
  logic [LANES*DW-1:0] rd_data;
  logic                rd_valid;
  logic [6:0]          shadow_cnt;
  logic [6:0]          active_words;
  logic                err_oob;

  int tests_run    = 0;
  int tests_failed = 0;

  fc_weight_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_en      (load_en),
    .load_k_word  (load_k_word),
    .load_data    (load_data),
    .swap         (swap),
    .rd_en        (rd_en),
    .rd_sub_cycle (rd_sub_cycle),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .shadow_cnt   (shadow_cnt),
    .active_words (active_words),
    .err_oob      (err_oob)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int k, input logic [31:0] d);
    load_en     = 1'b1;
    load_k_word = 7'(k);
    load_data   = d;
    tick();
    load_en     = 1'b0;
  endtask

  task automatic do_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
  endtask

  task automatic do_read(input int sc);
    rd_en        = 1'b1;
    rd_sub_cycle = 3'(sc);
    tick();
    rd_en        = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    tests_run++;
    if (rd_valid !== 1'b0 || rd_data !== '0 || shadow_cnt !== 7'd0 ||
        active_words !== 7'd0 || err_oob !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%b cnt=%0d act=%0d err=%b, want all 0",
               rd_valid, shadow_cnt, active_words, err_oob);
    end
    rst_n = 1'b1;
    do_read(0);
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_read: valid=%b data_zero=%b, want 1/1", rd_valid, rd_data == '0);
    end
  endtask

  task automatic test_load_swap_read();
    logic [31:0] exp;
    for (int k = 0; k < 24; k++) do_load(k, 32'(k + 1));
    tests_run++;
    if (shadow_cnt !== 7'd24) begin
      tests_failed++;
      $display("FAIL load24_cnt: got %0d want 24", shadow_cnt);
    end
    do_swap();
    tests_run++;
    if (active_words !== 7'd24 || shadow_cnt !== 7'd0) begin
      tests_failed++;
      $display("FAIL swap24: act=%0d cnt=%0d want 24/0", active_words, shadow_cnt);
    end
    for (int sc = 0; sc < 3; sc++) begin
      do_read(sc);
      tests_run++;
      if (rd_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL read24_valid sc%0d: got %b want 1", sc, rd_valid);
      end
      for (int i = 0; i < LANES; i++) begin
        exp = (sc * LANES + i < 24) ? 32'(sc * LANES + i + 1) : 32'd0;
        tests_run++;
        if (rd_data[i*DW +: DW] !== exp) begin
          tests_failed++;
          $display("FAIL read24 sc%0d lane%0d: got %h want %h", sc, i, rd_data[i*DW +: DW], exp);
        end
      end
    end
  endtask

  task automatic test_hold();
    do_read(1);
    tick();
    tests_run++;
    if (rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_valid: got %b want 0", rd_valid);
    end
    for (int i = 0; i < LANES; i++) begin
      tests_run++;
      if (rd_data[i*DW +: DW] !== 32'(13 + i)) begin
        tests_failed++;
        $display("FAIL hold lane%0d: got %h want %h", i, rd_data[i*DW +: DW], 32'(13 + i));
      end
    end
  endtask

  task automatic test_full();
    for (int k = 0; k < DEPTH; k++) do_load(k, 32'h1000 + 32'(k));
    tests_run++;
    if (shadow_cnt !== 7'd96) begin
      tests_failed++;
      $display("FAIL full_cnt: got %0d want 96", shadow_cnt);
    end
    do_load(0, 32'h1000);
    tests_run++;
    if (shadow_cnt !== 7'd96) begin
      tests_failed++;
      $display("FAIL saturate_cnt: got %0d want 96", shadow_cnt);
    end
    do_swap();
    tests_run++;
    if (active_words !== 7'd96 || shadow_cnt !== 7'd0) begin
      tests_failed++;
      $display("FAIL swap96: act=%0d cnt=%0d want 96/0", active_words, shadow_cnt);
    end
    do_read(7);
    for (int i = 0; i < LANES; i++) begin
      tests_run++;
      if (rd_data[i*DW +: DW] !== 32'h1000 + 32'(84 + i)) begin
        tests_failed++;
        $display("FAIL read96 sc7 lane%0d: got %h want %h", i, rd_data[i*DW +: DW],
                 32'h1000 + 32'(84 + i));
      end
    end
    do_read(0);
    for (int i = 0; i < LANES; i++) begin
      tests_run++;
      if (rd_data[i*DW +: DW] !== 32'h1000 + 32'(i)) begin
        tests_failed++;
        $display("FAIL read96 sc0 lane%0d: got %h want %h", i, rd_data[i*DW +: DW],
                 32'h1000 + 32'(i));
      end
    end
  endtask

  // Shadow is the bank written with k+1 earlier; word 9 still holds 10
  task automatic test_swap_with_load();
    logic [31:0] exp;
    for (int k = 0; k < 9; k++) do_load(k, 32'hA000 + 32'(k));
    load_en     = 1'b1;
    load_k_word = 7'd5;
    load_data   = 32'hBEEF0005;
    swap        = 1'b1;
    tick();
    load_en     = 1'b0;
    swap        = 1'b0;
    tests_run++;
    if (active_words !== 7'd10 || shadow_cnt !== 7'd0) begin
      tests_failed++;
      $display("FAIL swap_load: act=%0d cnt=%0d want 10/0", active_words, shadow_cnt);
    end
    do_read(0);
    for (int i = 0; i < LANES; i++) begin
      if (i == 5)      exp = 32'hBEEF0005;
      else if (i < 9)  exp = 32'hA000 + 32'(i);
      else if (i == 9) exp = 32'd10;
      else             exp = 32'd0;
      tests_run++;
      if (rd_data[i*DW +: DW] !== exp) begin
        tests_failed++;
        $display("FAIL swap_load lane%0d: got %h want %h", i, rd_data[i*DW +: DW], exp);
      end
    end
  endtask

  task automatic test_swap_with_read();
    logic [31:0] exp;
    for (int k = 0; k < LANES; k++) do_load(k, 32'hC000 + 32'(k));
    rd_en        = 1'b1;
    rd_sub_cycle = 3'd0;
    swap         = 1'b1;
    tick();
    swap         = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (i == 5)      exp = 32'hBEEF0005;
      else if (i < 9)  exp = 32'hA000 + 32'(i);
      else if (i == 9) exp = 32'd10;
      else             exp = 32'd0;
      tests_run++;
      if (rd_data[i*DW +: DW] !== exp) begin
        tests_failed++;
        $display("FAIL swap_read_old lane%0d: got %h want %h", i, rd_data[i*DW +: DW], exp);
      end
    end
    tick();
    rd_en = 1'b0;
    tests_run++;
    if (active_words !== 7'd12 || rd_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL swap_read_new: act=%0d valid=%b want 12/1", active_words, rd_valid);
    end
    for (int i = 0; i < LANES; i++) begin
      tests_run++;
      if (rd_data[i*DW +: DW] !== 32'hC000 + 32'(i)) begin
        tests_failed++;
        $display("FAIL swap_read_new lane%0d: got %h want %h", i, rd_data[i*DW +: DW],
                 32'hC000 + 32'(i));
      end
    end
  endtask

  task automatic test_oob_and_reset();
    tests_run++;
    if (err_oob !== 1'b0) begin
      tests_failed++;
      $display("FAIL oob_initial: got %b want 0", err_oob);
    end
    do_load(100, 32'hDEAD);
    tests_run++;
    if (err_oob !== 1'b1 || shadow_cnt !== 7'd0) begin
      tests_failed++;
      $display("FAIL oob_load: err=%b cnt=%0d want 1/0", err_oob, shadow_cnt);
    end
    do_load(3, 32'h33);
    tick();
    tests_run++;
    if (err_oob !== 1'b1 || shadow_cnt !== 7'd1) begin
      tests_failed++;
      $display("FAIL oob_sticky: err=%b cnt=%0d want 1/1", err_oob, shadow_cnt);
    end
    load_en     = 1'b1;
    load_k_word = 7'd4;
    load_data   = 32'h44;
    rd_en       = 1'b1;
    rst_n       = 1'b0;
    tick();
    load_en     = 1'b0;
    rd_en       = 1'b0;
    tests_run++;
    if (rd_valid !== 1'b0 || rd_data !== '0 || shadow_cnt !== 7'd0 ||
        active_words !== 7'd0 || err_oob !== 1'b0) begin
      tests_failed++;
      $display("FAIL midload_reset: valid=%b cnt=%0d act=%0d err=%b, want all 0",
               rd_valid, shadow_cnt, active_words, err_oob);
    end
    rst_n = 1'b1;
    do_load(0, 32'h55);
    tests_run++;
    if (shadow_cnt !== 7'd1) begin
      tests_failed++;
      $display("FAIL post_reset_cnt: got %0d want 1", shadow_cnt);
    end
    do_read(0);
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== '0) begin
      tests_failed++;
      $display("FAIL post_reset_read: valid=%b data_zero=%b want 1/1", rd_valid, rd_data == '0);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    load_en      = 1'b0;
    load_k_word  = 7'd0;
    load_data    = 32'd0;
    swap         = 1'b0;
    rd_en        = 1'b0;
    rd_sub_cycle = 3'd0;
    test_reset();
    test_load_swap_read();
    test_hold();
    test_full();
    test_swap_with_load();
    test_swap_with_read();
    test_oob_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
